// File: rtl/muller_c_seq_arbiter_if.sv
// Handshake bundle between the IO decode / C-element cell and the sequencing arbiter.
interface muller_c_seq_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            c_a;
    logic            c_b;
    logic            c_q;
    logic            done;
    logic [1:0]      err_code;
    logic            busy;

    // Environment side: requesters plus the C-element output
    modport master (
        output req,
        output c_q,
        input  grant,
        input  c_a,
        input  c_b,
        input  done,
        input  err_code,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        input  c_q,
        output grant,
        output c_a,
        output c_b,
        output done,
        output err_code,
        output busy
    );
endinterface

// File: rtl/muller_c_seq_arbiter.sv
// Round-robin arbiter that shares one Muller C-element between NREQ requesters and
// exercises it per grant: rise, hold-at-1, fall, hold-at-0, reporting done + err_code.
module muller_c_seq_arbiter #(
    parameter int NREQ        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 3,
    parameter int TIMEOUT     = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    muller_c_seq_arbiter_if.slave bus
);

    localparam int HOLD_LEN = HOLD_CYC + SYNC_STAGES;
    localparam int CNT_MAX  = (TIMEOUT > HOLD_LEN) ? TIMEOUT : HOLD_LEN;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_LEN - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_RISE = 2'b01;
    localparam logic [1:0] ERR_HOLD = 2'b10;
    localparam logic [1:0] ERR_FALL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RISE,
        S_HOLD1,
        S_FALL,
        S_HOLD0,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [PW-1:0]          r_ptr;
    logic [1:0]             r_code;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [NREQ-1:0]        r_grant;
    logic                   r_c_a;
    logic                   r_c_b;
    logic                   r_done;
    logic [1:0]             r_err_code;
    logic                   r_busy;

    logic                   w_c_sync;
    logic                   w_found;
    logic [PW-1:0]          w_win;
    logic [PW-1:0]          w_idx;

    assign w_c_sync = r_sync[SYNC_STAGES-1];

    // c_q is asynchronous to clk; every check uses only the last synchronizer stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.c_q};
        end
    end

    // Round-robin search starting one past the last winner, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = PW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Sequencing FSM; all outputs registered so they change on the edge entering a state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ptr      <= PW'(NREQ - 1);
            r_code     <= ERR_OK;
            r_grant    <= '0;
            r_c_a      <= 1'b0;
            r_c_b      <= 1'b0;
            r_done     <= 1'b0;
            r_err_code <= ERR_OK;
            r_busy     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err_code <= ERR_OK;
            r_cnt      <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (|bus.req) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_ptr   <= w_win;
                        r_grant <= NREQ'(1) << w_win;
                        r_code  <= ERR_OK;
                        r_c_a   <= 1'b1;
                        r_c_b   <= 1'b1;
                        r_state <= S_RISE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RISE: begin
                    if (w_c_sync) begin
                        r_cnt   <= '0;
                        r_c_a   <= 1'b0;
                        r_c_b   <= 1'b1;
                        r_state <= S_HOLD1;
                    end else if (r_cnt == TO_LAST) begin
                        r_cnt   <= '0;
                        r_code  <= ERR_RISE;
                        r_c_a   <= 1'b0;
                        r_c_b   <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_HOLD1: begin
                    if (!w_c_sync) begin
                        r_cnt   <= '0;
                        r_code  <= ERR_HOLD;
                        r_c_a   <= 1'b0;
                        r_c_b   <= 1'b0;
                        r_state <= S_ERR;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_c_a   <= 1'b0;
                        r_c_b   <= 1'b0;
                        r_state <= S_FALL;
                    end
                end
                S_FALL: begin
                    if (!w_c_sync) begin
                        r_cnt   <= '0;
                        r_c_a   <= 1'b1;
                        r_c_b   <= 1'b0;
                        r_state <= S_HOLD0;
                    end else if (r_cnt == TO_LAST) begin
                        r_cnt   <= '0;
                        r_code  <= ERR_FALL;
                        r_state <= S_ERR;
                    end
                end
                S_HOLD0: begin
                    if (w_c_sync) begin
                        r_cnt   <= '0;
                        r_code  <= ERR_HOLD;
                        r_c_a   <= 1'b0;
                        r_c_b   <= 1'b0;
                        r_state <= S_ERR;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_cnt      <= '0;
                        r_c_a      <= 1'b0;
                        r_c_b      <= 1'b0;
                        r_done     <= 1'b1;
                        r_err_code <= ERR_OK;
                        r_state    <= S_DONE;
                    end
                end
                S_ERR: begin
                    // Let the cell settle low (or give up) before reporting
                    if (!w_c_sync || r_cnt == TO_LAST) begin
                        r_cnt      <= '0;
                        r_done     <= 1'b1;
                        r_err_code <= r_code;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_grant <= '0;
                    r_c_a   <= 1'b0;
                    r_c_b   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.c_a      = r_c_a;
    assign bus.c_b      = r_c_b;
    assign bus.done     = r_done;
    assign bus.err_code = r_err_code;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_muller_c_seq_arbiter.sv
// Bench for muller_c_seq_arbiter: behavioural C-element with fault modes, vector table,
// scoreboard of expected {grant, err_code} popped on every done pulse.
module tb_muller_c_seq_arbiter;

    localparam int M_IDEAL  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_FOLLOW = 3;

    typedef struct {
        int         mode;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] err;
        int         lat;
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cq    = 1'b0;
    int   mode  = M_IDEAL;

    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t sb[$];
    vec_t vecs[5];

    muller_c_seq_arbiter_if #(.NREQ(4)) bus ();

    muller_c_seq_arbiter #(
        .NREQ(4),
        .SYNC_STAGES(2),
        .HOLD_CYC(3),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Zero-delay C-element with selectable faults
    always @(bus.c_a, bus.c_b, mode) begin
        case (mode)
            M_IDEAL:  if (bus.c_a == bus.c_b) cq = bus.c_a;
            M_STUCK0: cq = 1'b0;
            M_STUCK1: cq = 1'b1;
            default:  cq = bus.c_a;
        endcase
    end
    assign bus.c_q = cq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer and err_code-outside-done check
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_grant", 32'(bus.grant), 32'(e.grant));
                    check("sb_err_code", 32'(bus.err_code), 32'(e.err));
                end
            end else begin
                check("err_code_idle", 32'(bus.err_code), 32'd0);
            end
        end
    end

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < limit);
        if (!bus.done) check("done_timeout", 32'(lat), 32'(limit + 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_mode(input int m);
        mode = m;
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int gap;
        logic [1:0] exp_ab;
        logic [3:0] exp_g;

        vecs[0] = '{M_IDEAL,  4'b0001, 4'b0001, 2'b00, 18};
        vecs[1] = '{M_STUCK0, 4'b0010, 4'b0010, 2'b01, 11};
        vecs[2] = '{M_FOLLOW, 4'b0001, 4'b0001, 2'b10, 9};
        vecs[3] = '{M_STUCK1, 4'b0001, 4'b0001, 2'b11, 24};
        vecs[4] = '{M_IDEAL,  4'b0100, 4'b0100, 2'b00, 18};

        bus.req = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_c_a", 32'(bus.c_a), 32'd0);
        check("rst_c_b", 32'(bus.c_b), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Cycle-by-cycle drive sequence of an ideal transaction
        sb.push_back('{4'b0001, 2'b00});
        bus.req = 4'b0001;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ab = (k >= 2 && k <= 4)  ? 2'b11 :
                     (k >= 5 && k <= 9)  ? 2'b01 :
                     (k >= 13 && k <= 17) ? 2'b10 : 2'b00;
            exp_g  = (k >= 2 && k <= 18) ? 4'b0001 : 4'b0000;
            check($sformatf("seq_cyc%0d", k),
                  32'({bus.c_a, bus.c_b, bus.grant, bus.busy, bus.done}),
                  32'({exp_ab, exp_g, (k <= 18), (k == 18)}));
            if (k == 18) bus.req = '0;
        end

        // Table of single-requester transactions under each C-element model
        foreach (vecs[i]) begin
            set_mode(vecs[i].mode);
            sb.push_back('{vecs[i].grant, vecs[i].err});
            bus.req = vecs[i].req;
            wait_done(40, lat);
            bus.req = '0;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_ab_at_done", i), 32'({bus.c_a, bus.c_b}), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_grant_after", i), 32'(bus.grant), 32'd0);
            check($sformatf("vec%0d_busy_after", i), 32'(bus.busy), 32'd0);
        end

        // Asynchronous reset in the middle of HOLD1
        set_mode(M_IDEAL);
        bus.req = 4'b0001;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_ab", 32'({bus.c_a, bus.c_b}), 32'b01);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ab", 32'({bus.c_a, bus.c_b}), 32'd0);
        check("async_rst_grant", 32'(bus.grant), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0011;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{4'b0001, 2'b00});
        wait_done(40, lat);
        bus.req = '0;
        check("post_rst_latency", 32'(lat), 32'd18);
        @(negedge clk);

        // All requesters held: round-robin order with one IDLE cycle between
        do_reset();
        sb.push_back('{4'b0001, 2'b00});
        sb.push_back('{4'b0010, 2'b00});
        sb.push_back('{4'b0100, 2'b00});
        sb.push_back('{4'b1000, 2'b00});
        sb.push_back('{4'b0001, 2'b00});
        bus.req = 4'b1111;
        wait_done(40, lat);
        check("rr0_latency", 32'(lat), 32'd18);
        for (int t = 1; t < 5; t++) begin
            gap = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                if (!bus.busy) gap++;
            end while (!bus.busy && gap < 10);
            check($sformatf("rr%0d_idle_gap", t), 32'(gap), 32'd1);
            wait_done(40, lat);
            check($sformatf("rr%0d_latency", t), 32'(lat), 32'd17);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("rr_end_busy", 32'(bus.busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muller_c_seq_arbiter.md
Name: muller_c_seq_arbiter

Overview:
- Clocked controller that shares a single Muller C-element cell between NREQ requesters.
- For each granted request it runs a full exercise of the C-element: rise, hold-at-1, fall, hold-at-0. It drives both C-element inputs and watches the synchronized output.
- Per-transaction result is reported as done plus an error code. Detected faults are a rise/fall timeout or a broken hold property.
- Sits between the project IO decode and the async c_element instance.

Parameters:
NREQ, 4, number of requesters (2..8)
SYNC_STAGES, 2, flops in the c_q synchronizer (>=2)
HOLD_CYC, 3, hold-check cycles per hold phase, excluding sync lag
TIMEOUT, 8, max cycles allowed in RISE/FALL/ERR (>=SYNC_STAGES+2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until done
grant  out  NREQ  one-hot grant, asserted from RISE through DONE
c_a  out  1  C-element input A, registered
c_b  out  1  C-element input B, registered
c_q  in  1  C-element output, asynchronous to clk
done  out  1  one-cycle pulse, transaction finished
err_code  out  2  valid with done: 00 ok, 01 rise timeout, 10 hold violation, 11 fall timeout
busy  out  1  high when state is not IDLE

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release.
  - All outputs 0 (grant, c_a, c_b, done, err_code, busy); state IDLE.
  - Synchronizer flops cleared; round-robin pointer = NREQ-1, so req[0] wins first.
  - Reset mid-transaction aborts immediately; c_a/c_b drop in the same instant.
- Synchronizer: c_sync = c_q after SYNC_STAGES flops. All checks use c_sync only.
- Registered outputs: c_a, c_b and grant change on the edge that enters a state.
- States and drive values (c_a,c_b):
  - IDLE (0,0): any req → ARB.
  - ARB (0,0): round-robin pick, searching from pointer+1 with wrap. Latch winner; pointer = winner; → RISE.
  - RISE (1,1): cycle counter runs. c_sync=1 → HOLD1. Counter reaches TIMEOUT-1 with c_sync=0 → ERR, code 01.
  - HOLD1 (0,1): lasts HOLD_CYC+SYNC_STAGES cycles. Any cycle with c_sync=0 → ERR, code 10. On completion → FALL.
  - FALL (0,0): c_sync=0 → HOLD0. TIMEOUT-1 reached → ERR, code 11.
  - HOLD0 (1,0): same length as HOLD1. Any c_sync=1 → ERR, code 10. On completion → DONE.
  - DONE (0,0): done=1, err_code=00 (or latched code if arriving from ERR); grant cleared on exit; → IDLE.
  - ERR (0,0): wait for c_sync=0 or TIMEOUT cycles, then → DONE carrying the latched code.
- Counter clears on every state entry.
- Zero-delay C-element timing:
  - RISE and FALL each take SYNC_STAGES+1 cycles.
  - Full transaction = 1+3+5+3+5+1 = 18 cycles at defaults.
  - done is asserted in cycle 18 after ARB entry.
- Requester rules:
  - req deassert after grant is ignored; the transaction completes.
  - A new transaction for the same requester needs req still high in IDLE, after done.
- Arbitration:
  - Simultaneous requests are served round-robin; no requester is skipped twice in a row.
  - Back-to-back: IDLE is always visited for exactly 1 cycle between transactions.
- err_code holds its value only during the done cycle; 00 otherwise.

Test Plan:
- Ideal C-element model, req=0001 held → grant=0001 from cycle 2. c_a/c_b sequence: 11×3, 01×5, 00×3, 10×5. done at cycle 18 with err_code=00.
- req=1111 held through 4 transactions → grant order 0001, 0010, 0100, 1000, then 0001. Each done with 00; busy low exactly 1 cycle between transactions.
- c_q stuck at 0, req=0010 → ERR after RISE runs 8 cycles. done pulse with err_code=01. c_a=c_b=0 after ERR; grant cleared after done.
- Faulty model where c_q follows c_a only, req=0001 → in HOLD1, c_sync=0 at the 3rd HOLD1 cycle. done with err_code=10; no FALL/HOLD0 drive observed.
- c_q stuck at 1, req=0001 → HOLD1 passes; FALL times out. done with err_code=11 after ERR spends 8 cycles.
- rst_n pulsed low mid-HOLD1 → c_a, c_b, grant, busy = 0 asynchronously. After release with req=0011, req[0] is granted first.
